// File: rtl/rv_trace_encoder.sv
// rv_trace_encoder
//   Retirement trace producer. One commit record per retired instruction is
//   captured at writeback into a record FIFO and serialized as little-endian
//   byte packets on a valid/ready byte stream.
//
//   Packets:
//     instruction : hdr{2'b00,rw,mem,mw,3'b0}, pc[4], instr[4],
//                   [rd data[4] if rw], [sel, addr[4], data[4] if mem]
//     overflow    : 0x40, dropped-record count (saturating at 255)
//     sync        : 0x80, A5, A5, 5A, 5A (only with TRACE_SYNC_EN)
//
//   Build option: define TRACE_SYNC_EN to emit a sync packet after reset and
//   after every SYNC_PERIOD instruction packets.
//
//   Ports:
//     i_clk, i_reset          clock, synchronous active-high reset
//     i_commit_valid          one instruction retires this cycle
//     i_pc                    PC[31:2] of retiring instruction
//     i_instr                 instruction word
//     i_reg_write/i_reg_data  rd write flag and data
//     i_mem_write/i_mem_read  store / load flags
//     i_mem_addr/i_mem_sel    memory address and byte lanes
//     i_mem_data              store or load data
//     o_tx_data/o_tx_valid    output byte stream
//     i_tx_ready              sink accepts byte
//     o_overflow              sticky: at least one record dropped since reset
module rv_trace_encoder #(
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter int unsigned SYNC_PERIOD = 256
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_commit_valid,
  input  logic [29:0] i_pc,
  input  logic [31:0] i_instr,
  input  logic        i_reg_write,
  input  logic [31:0] i_reg_data,
  input  logic        i_mem_write,
  input  logic        i_mem_read,
  input  logic [31:0] i_mem_addr,
  input  logic [3:0]  i_mem_sel,
  input  logic [31:0] i_mem_data,
  output logic [7:0]  o_tx_data,
  output logic        o_tx_valid,
  input  logic        i_tx_ready,
  output logic        o_overflow
);

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || SYNC_PERIOD < 1) begin : g_bad_param
    $error("rv_trace_encoder: FIFO_DEPTH must be a power of 2 >= 2 and SYNC_PERIOD >= 1");
  end

  localparam int unsigned AW = $clog2(FIFO_DEPTH);

  localparam logic [3:0] S_IDLE       = 4'd0;
  localparam logic [3:0] S_HDR        = 4'd1;
  localparam logic [3:0] S_PC         = 4'd2;
  localparam logic [3:0] S_INSTR      = 4'd3;
  localparam logic [3:0] S_RDATA      = 4'd4;
  localparam logic [3:0] S_MSEL       = 4'd5;
  localparam logic [3:0] S_MADDR      = 4'd6;
  localparam logic [3:0] S_MDATA      = 4'd7;
  localparam logic [3:0] S_OVF_HDR    = 4'd8;
  localparam logic [3:0] S_OVF_CNT    = 4'd9;
  localparam logic [3:0] S_SYNC_HDR   = 4'd10;
  localparam logic [3:0] S_SYNC_MAGIC = 4'd11;

  typedef struct packed {
    logic [7:0]  tag;    // records dropped just before this one
    logic [29:0] pc;
    logic [31:0] instr;
    logic        rw;
    logic [31:0] rdata;
    logic        mw;
    logic        mr;
    logic [3:0]  sel;
    logic [31:0] addr;
    logic [31:0] mdata;
  } rec_t;

  rec_t          mem [FIFO_DEPTH];
  rec_t          rec_in;
  rec_t          head;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   level;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;

  logic [3:0]    state;
  logic [1:0]    bcnt;
  logic [7:0]    ovf_cnt;
  logic          ovf_then_entry;
  logic [7:0]    drop_cnt;
  logic          overflow;
  logic          head_mem;
  logic          xfer;
  logic          last4;
  logic          pkt_done;
  logic          sync_go;
  logic          start_sync;
  logic          start_tag;
  logic          start_solo;
  logic          start_instr;
  logic [7:0]    tx_byte;

  function automatic logic [7:0] pick(input logic [31:0] w, input logic [1:0] i);
    logic [7:0] b;
    case (i)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    return b;
  endfunction

  assign full     = (level == (AW + 1)'(FIFO_DEPTH));
  assign empty    = (level == '0);
  assign push     = i_commit_valid & ~full;
  assign head     = mem[rd_ptr];
  assign head_mem = head.mr | head.mw;

  assign o_tx_valid = (state != S_IDLE);
  assign xfer       = o_tx_valid & i_tx_ready;
  assign last4      = (bcnt == 2'd3);

  // An instruction packet ends on whichever field is its last present one.
  assign pkt_done = xfer & last4 &
                    (((state == S_INSTR) & ~head.rw & ~head_mem) |
                     ((state == S_RDATA) & ~head_mem) |
                     (state == S_MDATA));
  assign pop = pkt_done;

  always_comb begin
    rec_in.tag   = drop_cnt;
    rec_in.pc    = i_pc;
    rec_in.instr = i_instr;
    rec_in.rw    = i_reg_write;
    rec_in.rdata = i_reg_data;
    rec_in.mw    = i_mem_write;
    rec_in.mr    = i_mem_read;
    rec_in.sel   = i_mem_sel;
    rec_in.addr  = i_mem_addr;
    rec_in.mdata = i_mem_data;
  end

  // IDLE arbitration: sync, then overflow (tagged head or standalone), then record.
  // A standalone overflow packet yields to a same-cycle push, which carries the tag instead.
  always_comb begin
    start_sync  = (state == S_IDLE) & sync_go;
    start_tag   = (state == S_IDLE) & ~sync_go & ~empty & (head.tag != '0);
    start_solo  = (state == S_IDLE) & ~sync_go & empty & (drop_cnt != '0) & ~i_commit_valid;
    start_instr = (state == S_IDLE) & ~sync_go & ~empty & (head.tag == '0);
  end

  always_ff @(posedge i_clk) begin
    if (push) mem[wr_ptr] <= rec_in;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      level <= level + 1'b1;
      else if (pop && !push) level <= level - 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      drop_cnt <= '0;
      overflow <= 1'b0;
    end else begin
      if (i_commit_valid && full) begin
        overflow <= 1'b1;
        if (drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
      end else if (push || start_solo) begin
        drop_cnt <= '0;
      end
    end
  end

  assign o_overflow = overflow;

`ifdef TRACE_SYNC_EN
  localparam int unsigned SW = $clog2(SYNC_PERIOD) + 1;
  logic          sync_pending;
  logic [SW-1:0] sync_cnt;

  assign sync_go = sync_pending;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      sync_pending <= 1'b1;
      sync_cnt     <= '0;
    end else begin
      if (start_sync) sync_pending <= 1'b0;
      if (pkt_done) begin
        if (sync_cnt == SW'(SYNC_PERIOD - 1)) begin
          sync_cnt     <= '0;
          sync_pending <= 1'b1;
        end else begin
          sync_cnt <= sync_cnt + 1'b1;
        end
      end
    end
  end
`else
  assign sync_go = 1'b0;
`endif

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state          <= S_IDLE;
      bcnt           <= '0;
      ovf_cnt        <= '0;
      ovf_then_entry <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          bcnt <= '0;
          if (start_sync) begin
            state <= S_SYNC_HDR;
          end else if (start_tag) begin
            ovf_cnt        <= head.tag;
            ovf_then_entry <= 1'b1;
            state          <= S_OVF_HDR;
          end else if (start_solo) begin
            ovf_cnt        <= drop_cnt;
            ovf_then_entry <= 1'b0;
            state          <= S_OVF_HDR;
          end else if (start_instr) begin
            state <= S_HDR;
          end
        end
        S_HDR: if (xfer) state <= S_PC;
        S_PC: if (xfer) begin
          bcnt <= bcnt + 1'b1;
          if (last4) state <= S_INSTR;
        end
        S_INSTR: if (xfer) begin
          bcnt <= bcnt + 1'b1;
          if (last4) state <= head.rw ? S_RDATA : (head_mem ? S_MSEL : S_IDLE);
        end
        S_RDATA: if (xfer) begin
          bcnt <= bcnt + 1'b1;
          if (last4) state <= head_mem ? S_MSEL : S_IDLE;
        end
        S_MSEL: if (xfer) state <= S_MADDR;
        S_MADDR: if (xfer) begin
          bcnt <= bcnt + 1'b1;
          if (last4) state <= S_MDATA;
        end
        S_MDATA: if (xfer) begin
          bcnt <= bcnt + 1'b1;
          if (last4) state <= S_IDLE;
        end
        S_OVF_HDR: if (xfer) state <= S_OVF_CNT;
        // A tagged head goes straight into its own packet so the tag is not re-sent.
        S_OVF_CNT: if (xfer) state <= ovf_then_entry ? S_HDR : S_IDLE;
        S_SYNC_HDR: if (xfer) state <= S_SYNC_MAGIC;
        S_SYNC_MAGIC: if (xfer) begin
          bcnt <= bcnt + 1'b1;
          if (last4) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Output byte is a function of registered state and the unpopped head entry,
  // so it holds steady while the sink stalls.
  always_comb begin
    tx_byte = '0;
    case (state)
      S_HDR:        tx_byte = {2'b00, head.rw, head_mem, head.mw, 3'b000};
      S_PC:         tx_byte = pick({head.pc, 2'b00}, bcnt);
      S_INSTR:      tx_byte = pick(head.instr, bcnt);
      S_RDATA:      tx_byte = pick(head.rdata, bcnt);
      S_MSEL:       tx_byte = {4'b0000, head.sel};
      S_MADDR:      tx_byte = pick(head.addr, bcnt);
      S_MDATA:      tx_byte = pick(head.mdata, bcnt);
      S_OVF_HDR:    tx_byte = 8'h40;
      S_OVF_CNT:    tx_byte = ovf_cnt;
      S_SYNC_HDR:   tx_byte = 8'h80;
      S_SYNC_MAGIC: tx_byte = bcnt[1] ? 8'h5A : 8'hA5;
      default:      tx_byte = '0;
    endcase
  end

  assign o_tx_data = tx_byte;

endmodule

// File: tb/tb_rv_trace_encoder.sv
module tb_rv_trace_encoder;
  localparam int unsigned DEPTH  = 8;
  localparam int unsigned PERIOD = 4;
`ifdef TRACE_SYNC_EN
  localparam int SYNC_LEN = 5;
`else
  localparam int SYNC_LEN = 0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        commit_valid;
  logic [29:0] pc;
  logic [31:0] instr;
  logic        reg_write;
  logic [31:0] reg_data;
  logic        mem_write;
  logic        mem_read;
  logic [31:0] mem_addr;
  logic [3:0]  mem_sel;
  logic [31:0] mem_data;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        overflow;

  always #5 clk = ~clk;

  rv_trace_encoder #(.FIFO_DEPTH(DEPTH), .SYNC_PERIOD(PERIOD)) dut (
    .i_clk(clk), .i_reset(reset), .i_commit_valid(commit_valid), .i_pc(pc),
    .i_instr(instr), .i_reg_write(reg_write), .i_reg_data(reg_data),
    .i_mem_write(mem_write), .i_mem_read(mem_read), .i_mem_addr(mem_addr),
    .i_mem_sel(mem_sel), .i_mem_data(mem_data), .o_tx_data(tx_data),
    .o_tx_valid(tx_valid), .i_tx_ready(tx_ready), .o_overflow(overflow)
  );

  typedef struct {
    logic [29:0] pc;
    logic [31:0] instr;
    logic        rw;
    logic [31:0] rdata;
    logic        mw;
    logic        mr;
    logic [3:0]  sel;
    logic [31:0] addr;
    logic [31:0] mdata;
  } rec_t;

  logic [7:0]  got[$];
  logic [7:0]  exp_q[$];
  int          checks = 0;
  int          failures = 0;
  int unsigned since_sync;
  int unsigned drop_cnt;

  // Byte transfers at the next rising edge when valid & ready here.
  always @(negedge clk) begin
    if (!reset && tx_valid && tx_ready) got.push_back(tx_data);
  end

  // ---------------- reference model: expected byte stream ----------------
  function automatic void put32(input logic [31:0] w);
    for (int i = 0; i < 4; i++) exp_q.push_back(w[8*i +: 8]);
  endfunction

  function automatic void model_sync();
`ifdef TRACE_SYNC_EN
    exp_q.push_back(8'h80); exp_q.push_back(8'hA5); exp_q.push_back(8'hA5);
    exp_q.push_back(8'h5A); exp_q.push_back(8'h5A);
`endif
  endfunction

  function automatic void model_reset();
    exp_q.delete();
    since_sync = 0;
    drop_cnt = 0;
    model_sync();
  endfunction

  function automatic void model_commit(input rec_t r, input bit accepted);
    logic m;
    if (!accepted) begin
      if (drop_cnt < 255) drop_cnt++;
      return;
    end
    if (drop_cnt != 0) begin
      exp_q.push_back(8'h40);
      exp_q.push_back(8'(drop_cnt));
      drop_cnt = 0;
    end
    m = r.mr | r.mw;
    exp_q.push_back({2'b00, r.rw, m, r.mw, 3'b000});
    put32({r.pc, 2'b00});
    put32(r.instr);
    if (r.rw) put32(r.rdata);
    if (m) begin
      exp_q.push_back({4'b0000, r.sel});
      put32(r.addr);
      put32(r.mdata);
    end
`ifdef TRACE_SYNC_EN
    since_sync++;
    if (since_sync == PERIOD) begin
      model_sync();
      since_sync = 0;
    end
`endif
  endfunction

  function automatic void model_flush_drops();
    if (drop_cnt != 0) begin
      exp_q.push_back(8'h40);
      exp_q.push_back(8'(drop_cnt));
      drop_cnt = 0;
    end
  endfunction

  function automatic rec_t rand_rec();
    rec_t r;
    int unsigned kind;
    kind    = $urandom_range(0, 3);
    r.pc    = 30'($urandom);
    r.instr = $urandom;
    r.rdata = $urandom;
    r.addr  = $urandom;
    r.mdata = $urandom;
    r.sel   = 4'($urandom);
    r.rw    = (kind == 0) || (kind == 1);
    r.mr    = (kind == 1);
    r.mw    = (kind == 2);
    return r;
  endfunction

  function automatic int first_diff();
    int n;
    n = (got.size() < exp_q.size()) ? got.size() : exp_q.size();
    for (int i = 0; i < n; i++) if (got[i] !== exp_q[i]) return i;
    return -1;
  endfunction

  // ---------------- stimulus helpers (called at posedge + 2) ----------------
  task automatic drive_commit(input rec_t r);
    pc = r.pc; instr = r.instr; reg_write = r.rw; reg_data = r.rdata;
    mem_write = r.mw; mem_read = r.mr; mem_addr = r.addr; mem_sel = r.sel;
    mem_data = r.mdata; commit_valid = 1'b1;
    @(posedge clk); #2;
    commit_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk); #2;
    reset = 1'b1;
    commit_valid = 1'b0;
    repeat (2) begin @(posedge clk); #2; end
    got.delete();
    model_reset();
    reset = 1'b0;
  endtask

  task automatic wait_drain(input int unsigned limit);
    int unsigned n = 0;
    while (got.size() < exp_q.size() && n < limit) begin
      @(posedge clk); #2;
      n++;
    end
    repeat (30) begin @(posedge clk); #2; end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (tx_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", tx_valid); end
    checks++; if (tx_data !== 8'h00) begin failures++; $display("FAIL reset_data got=%02h exp=00", tx_data); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
  endtask

  task automatic test_basic();
    rec_t a, b;
    int d, o;
    tx_ready = 1'b1;
    do_reset();
    a = '{pc: 30'h20000000, instr: 32'h00500093, rw: 1'b1, rdata: 32'd5,
          mw: 1'b0, mr: 1'b0, sel: 4'h0, addr: 32'h0, mdata: 32'h0};
    b = '{pc: 30'h20000001, instr: 32'h00112023, rw: 1'b0, rdata: 32'h0,
          mw: 1'b1, mr: 1'b0, sel: 4'hF, addr: 32'h1000, mdata: 32'hDEADBEEF};
    model_commit(a, 1'b1); drive_commit(a);
    model_commit(b, 1'b1); drive_commit(b);
    wait_drain(500);
    checks++; if (got.size() != exp_q.size()) begin failures++; $display("FAIL basic_len got=%0d exp=%0d", got.size(), exp_q.size()); end
    d = first_diff();
    checks++; if (d >= 0) begin failures++; $display("FAIL basic_bytes idx=%0d got=%02h exp=%02h", d, got[d], exp_q[d]); end
    o = SYNC_LEN;
    checks++;
    if (got.size() < o + 31) begin
      failures++; $display("FAIL basic_literal_len got=%0d exp=%0d", got.size(), o + 31);
    end else begin
      if (got[o] !== 8'h20 || got[o+4] !== 8'h80 || got[o+5] !== 8'h93 || got[o+9] !== 8'h05) begin
        failures++; $display("FAIL basic_addi got=%02h %02h %02h %02h exp=20 80 93 05", got[o], got[o+4], got[o+5], got[o+9]);
      end
      checks++;
      if (got[o+13] !== 8'h18 || got[o+22] !== 8'h0F || got[o+24] !== 8'h10 || got[o+27] !== 8'hEF || got[o+30] !== 8'hDE) begin
        failures++; $display("FAIL basic_sw got=%02h %02h %02h %02h %02h exp=18 0F 10 EF DE", got[o+13], got[o+22], got[o+24], got[o+27], got[o+30]);
      end
    end
`ifdef TRACE_SYNC_EN
    checks++; if (got.size() < 1 || got[0] !== 8'h80) begin failures++; $display("FAIL basic_sync_first got=%0d exp=128", (got.size() > 0) ? int'(got[0]) : -1); end
`endif
  endtask

  task automatic test_stall();
    rec_t r;
    int base, d, n;
    tx_ready = 1'b1;
    do_reset();
    wait_drain(100);
    base = got.size();
    r = rand_rec();
    model_commit(r, 1'b1);
    drive_commit(r);
    n = 0;
    while (got.size() < base + 3 && n < 100) begin @(posedge clk); #2; n++; end
    tx_ready = 1'b0;
    repeat (5) begin
      @(negedge clk);
      checks++; if (tx_valid !== 1'b1) begin failures++; $display("FAIL stall_valid got=%b exp=1", tx_valid); end
      checks++; if (tx_data !== exp_q[base+3]) begin failures++; $display("FAIL stall_data got=%02h exp=%02h", tx_data, exp_q[base+3]); end
    end
    checks++; if (got.size() != base + 3) begin failures++; $display("FAIL stall_count got=%0d exp=%0d", got.size(), base + 3); end
    @(posedge clk); #2;
    tx_ready = 1'b1;
    wait_drain(500);
    checks++; if (got.size() != exp_q.size()) begin failures++; $display("FAIL stall_len got=%0d exp=%0d", got.size(), exp_q.size()); end
    d = first_diff();
    checks++; if (d >= 0) begin failures++; $display("FAIL stall_bytes idx=%0d got=%02h exp=%02h", d, got[d], exp_q[d]); end
  endtask

  task automatic test_back_to_back();
    rec_t r;
    int d;
    tx_ready = 1'b1;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      r = rand_rec();
      model_commit(r, 1'b1);
      drive_commit(r);
    end
    wait_drain(1000);
    checks++; if (got.size() != exp_q.size()) begin failures++; $display("FAIL b2b_len got=%0d exp=%0d", got.size(), exp_q.size()); end
    d = first_diff();
    checks++; if (d >= 0) begin failures++; $display("FAIL b2b_bytes idx=%0d got=%02h exp=%02h", d, got[d], exp_q[d]); end
  endtask

  task automatic test_overflow();
    rec_t r;
    int d;
    // Tagged: a record pushed during the drain carries the drop count.
    tx_ready = 1'b0;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      r = rand_rec(); model_commit(r, i < 8); drive_commit(r);
    end
    @(negedge clk);
    checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_sticky got=%b exp=1", overflow); end
    @(posedge clk); #2;
    tx_ready = 1'b1;
    repeat (40) begin @(posedge clk); #2; end
    r = rand_rec(); model_commit(r, 1'b1); drive_commit(r);
    wait_drain(1500);
    checks++; if (got.size() != exp_q.size()) begin failures++; $display("FAIL ovf_tag_len got=%0d exp=%0d", got.size(), exp_q.size()); end
    d = first_diff();
    checks++; if (d >= 0) begin failures++; $display("FAIL ovf_tag_bytes idx=%0d got=%02h exp=%02h", d, got[d], exp_q[d]); end

    // Standalone: FIFO drains first, then a lone overflow packet, then a clean record.
    tx_ready = 1'b0;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      r = rand_rec(); model_commit(r, i < 8); drive_commit(r);
    end
    tx_ready = 1'b1;
    model_flush_drops();
    wait_drain(1500);
    r = rand_rec(); model_commit(r, 1'b1); drive_commit(r);
    wait_drain(500);
    checks++; if (got.size() != exp_q.size()) begin failures++; $display("FAIL ovf_solo_len got=%0d exp=%0d", got.size(), exp_q.size()); end
    d = first_diff();
    checks++; if (d >= 0) begin failures++; $display("FAIL ovf_solo_bytes idx=%0d got=%02h exp=%02h", d, got[d], exp_q[d]); end

    // Saturation of the drop count at 255.
    tx_ready = 1'b0;
    do_reset();
    for (int i = 0; i < 8 + 260; i++) begin
      r = rand_rec(); model_commit(r, i < 8); drive_commit(r);
    end
    tx_ready = 1'b1;
    model_flush_drops();
    wait_drain(1500);
    checks++; if (got.size() != exp_q.size()) begin failures++; $display("FAIL ovf_sat_len got=%0d exp=%0d", got.size(), exp_q.size()); end
    d = first_diff();
    checks++; if (d >= 0) begin failures++; $display("FAIL ovf_sat_bytes idx=%0d got=%02h exp=%02h", d, got[d], exp_q[d]); end
    checks++;
    if (got.size() < 2 || got[got.size()-2] !== 8'h40 || got[got.size()-1] !== 8'hFF) begin
      failures++; $display("FAIL ovf_sat_tail got_len=%0d exp=40 FF", got.size());
    end
  endtask

  task automatic test_reset_mid_packet();
    rec_t r;
    int base, d, n;
    tx_ready = 1'b1;
    do_reset();
    wait_drain(100);
    base = got.size();
    r = rand_rec();
    r.rw = 1'b1;
    model_commit(r, 1'b1);
    drive_commit(r);
    n = 0;
    while (got.size() < base + 6 && n < 100) begin @(posedge clk); #2; n++; end
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++; if (tx_valid !== 1'b0) begin failures++; $display("FAIL midrst_valid got=%b exp=0", tx_valid); end
    checks++; if (tx_data !== 8'h00) begin failures++; $display("FAIL midrst_data got=%02h exp=00", tx_data); end
    @(posedge clk); #2;
    got.delete();
    model_reset();
    reset = 1'b0;
    r = rand_rec();
    model_commit(r, 1'b1);
    drive_commit(r);
    wait_drain(500);
    checks++; if (got.size() != exp_q.size()) begin failures++; $display("FAIL midrst_len got=%0d exp=%0d", got.size(), exp_q.size()); end
    d = first_diff();
    checks++; if (d >= 0) begin failures++; $display("FAIL midrst_bytes idx=%0d got=%02h exp=%02h", d, got[d], exp_q[d]); end
  endtask

  task automatic test_random();
    int d;
    tx_ready = 1'b1;
    do_reset();
    for (int round = 0; round < 4; round++) begin
      fork
        begin : ready_driver
          bit stalled = 1'b0;
          logic [7:0] held = '0;
          repeat (150) begin
            @(negedge clk);
            if (stalled) begin
              checks++;
              if (tx_valid !== 1'b1 || tx_data !== held) begin
                failures++; $display("FAIL rand_hold got=%b/%02h exp=1/%02h", tx_valid, tx_data, held);
              end
            end
            stalled = tx_valid && !tx_ready;
            held = tx_data;
            @(posedge clk); #2;
            tx_ready = ($urandom_range(0, 3) != 0);
          end
        end
        begin : commit_driver
          rec_t r;
          for (int k = 0; k < 6; k++) begin
            repeat ($urandom_range(0, 12)) begin @(posedge clk); #2; end
            r = rand_rec();
            model_commit(r, 1'b1);
            drive_commit(r);
          end
        end
      join
      tx_ready = 1'b1;
      wait_drain(1000);
    end
    checks++; if (got.size() != exp_q.size()) begin failures++; $display("FAIL rand_len got=%0d exp=%0d", got.size(), exp_q.size()); end
    d = first_diff();
    checks++; if (d >= 0) begin failures++; $display("FAIL rand_bytes idx=%0d got=%02h exp=%02h", d, got[d], exp_q[d]); end
  endtask

  initial begin
    reset = 1'b1; tx_ready = 1'b0; commit_valid = 1'b0;
    pc = '0; instr = '0; reg_write = 1'b0; reg_data = '0; mem_write = 1'b0;
    mem_read = 1'b0; mem_addr = '0; mem_sel = '0; mem_data = '0;
    since_sync = 0; drop_cnt = 0;
    test_reset();
    test_basic();
    test_stall();
    test_back_to_back();
    test_overflow();
    test_reset_mid_packet();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
